// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Line level of the host frame after idx device falling edges:
    // 0 = start, 1..8 = data LSB first, 9 = parity, 10 and beyond = stop/idle.
    function automatic logic frame_bit(input logic [7:0] data, input logic parity,
                                       input logic [3:0] idx);
        logic [15:0] frame;
        frame = {5'h1f, 1'b1, parity, data, 1'b0};
        return frame[idx];
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - pin synchronizer for ps2 clock/data, falling-edge detect on clock
// Ports: clock, reset (sync, active-low); clk_in/data_in raw pin levels;
//        clk_sync/data_sync synchronized levels; clk_fall one-cycle pulse per clock falling edge.
module ps2_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [STAGES-1:0] clk_pipe_q, clk_pipe_d;
    logic [STAGES-1:0] data_pipe_q, data_pipe_d;
    logic              clk_prev_q, clk_prev_d;

    always_comb begin
        clk_pipe_d  = STAGES'({clk_pipe_q, clk_in});
        data_pipe_d = STAGES'({data_pipe_q, data_in});
        clk_prev_d  = clk_sync;
    end

    // Idle bus level is high, so reset to ones to avoid a spurious edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_pipe_q  <= '1;
            data_pipe_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_pipe_q  <= clk_pipe_d;
            data_pipe_q <= data_pipe_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_sync  = clk_pipe_q[STAGES-1];
    assign data_sync = data_pipe_q[STAGES-1];
    assign clk_fall  = clk_prev_q & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Ports: clock, reset (sync, active-low); tx_data/tx_start request, tx_busy/tx_done/tx_error/err_code
//        status; ps2_clk_in/ps2_data_in raw pins; ps2_clk_oe/ps2_data_oe pull-low enables;
//        rx_inhibit tells the receiver to ignore the bus.
// Macro PS2_HOST_TX_RETRY_EN: one automatic retransmission after a first failed attempt.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);

    localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] INHIBIT_LAST  = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    ps2_tx_state_e      state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         err_code_q, err_code_d;
`ifdef PS2_HOST_TX_RETRY_EN
    logic               retry_q, retry_d;
`endif

    logic       clk_sync, data_sync, clk_fall;
    logic       fail;
    logic [1:0] fail_code;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock     (clock),
        .reset     (reset),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            err_code_q <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            err_code_q <= err_code_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = ERR_TIMEOUT;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d   = INHIBIT;
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    bit_cnt_d = '0;
                    timer_d   = '0;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    state_d = REQ;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ, SEND, ACK, WAIT_IDLE: begin
                // Watchdog spans the gap to each next device edge.
                timer_d = clk_fall ? '0 : timer_q + 1'b1;
                if (timer_q == TIMEOUT_LIMIT) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    case (state_q)
                        REQ: state_d = SEND;
                        SEND: begin
                            if (clk_fall) begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                                if (bit_cnt_q == 4'd9) state_d = ACK;
                            end
                        end
                        ACK: begin
                            if (clk_fall) begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                                if (!data_sync) begin
                                    state_d = WAIT_IDLE;
                                end else begin
                                    fail      = 1'b1;
                                    fail_code = ERR_NOACK;
                                end
                            end
                        end
                        WAIT_IDLE: if (clk_sync && data_sync) state_d = DONE;
                        default: state_d = state_q;
                    endcase
                end
            end
            DONE, ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                state_d   = INHIBIT;
                timer_d   = '0;
                bit_cnt_d = '0;
            end else begin
                state_d    = ERR;
                err_code_d = fail_code;
            end
`else
            state_d    = ERR;
            err_code_d = fail_code;
`endif
        end
    end

    always_comb begin
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            INHIBIT: begin
                tx_busy    = 1'b1;
                ps2_clk_oe = 1'b1;
            end
            REQ: begin
                tx_busy     = 1'b1;
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = ~frame_bit(data_q, parity_q, bit_cnt_q);
            end
            SEND: begin
                tx_busy     = 1'b1;
                ps2_data_oe = ~frame_bit(data_q, parity_q, bit_cnt_q);
            end
            ACK, WAIT_IDLE: tx_busy  = 1'b1;
            DONE:           tx_done  = 1'b1;
            ERR:            tx_error = 1'b1;
            default:        tx_busy  = 1'b0;
        endcase
        rx_inhibit = tx_busy;
    end

    assign err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a wired-AND device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 5000;
    localparam int TMO = 1000;
    localparam int H   = 20;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int TO_LAT = 12003;
`else
    localparam int TO_LAT = 6002;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit)
    );

    always #5 clock = ~clock;

    int         cyc = 0, inh_cnt = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0;
    int         start_cyc = 0, err_cyc = 0;
    logic [3:0] err_snap = '0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_data_oe)  req_cnt <= req_cnt + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt  <= err_cnt + 1;
            err_cyc  <= cyc;
            err_snap <= {ps2_clk_oe, ps2_data_oe, tx_busy, rx_inhibit};
        end
        if (tx_start && !tx_busy) start_cyc <= cyc;
    end

    initial begin
        repeat (95000) @(posedge clock);
        $display("FAIL global_timeout: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(posedge clock); #1;
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clock); #1;
        tx_start = 1'b0;
    endtask

    // Device side: waits for the start bit, then clocks `pulses` bits, reading each on the rising edge.
    task automatic dev_frame(input int pulses, input bit ack, output logic [10:0] bits);
        int n = 0;
        bits = '0;
        @(negedge clock);
        while (!(!ps2_clk_oe && ps2_data_oe) && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20000) begin
            chk("req_wait_bound", 32'(n < 20000), 1);
            return;
        end
        repeat (30) @(negedge clock);
        bits[0] = ps2_data_in;
        for (int k = 1; k <= pulses; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = ps2_data_in;
            repeat (H) @(negedge clock);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int base, input int limit);
        int n = 0;
        while ((done_cnt + err_cnt) == base && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < limit), 1);
        repeat (4) @(negedge clock);
    endtask

    logic [10:0] bits;
    int b_inh, b_req, b_done, b_err, b_sum;

    initial begin
        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {tx_busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe, rx_inhibit}, 8'h00);
        @(posedge clock); #1 reset = 1'b1;

        // set-LEDs command, ACKed
        b_inh = inh_cnt; b_req = req_cnt; b_done = done_cnt; b_err = err_cnt; b_sum = done_cnt + err_cnt;
        start_tx(PS2_CMD_SET_LEDS);
        @(negedge clock);
        chk("busy_after_accept", {tx_busy, rx_inhibit}, 2'b11);
        dev_frame(11, 1'b1, bits);
        wait_end("ed_end_bound", b_sum, 500);
        chk("ed_frame", bits, frame_of(8'hED));
        chk("ed_parity", bits[9], 1);
        chk("ed_inhibit_cycles", inh_cnt - b_inh, INH);
        chk("ed_req_cycles", req_cnt - b_req, 1);
        chk("ed_done", done_cnt - b_done, 1);
        chk("ed_no_err", err_cnt - b_err, 0);
        chk("ed_err_code", err_code, 2'b00);
        chk("ed_idle", {tx_busy, ps2_clk_oe, ps2_data_oe}, 3'b000);

        // parity of 0x01 and 0x00
        b_sum = done_cnt + err_cnt;
        start_tx(8'h01);
        dev_frame(11, 1'b1, bits);
        wait_end("x01_end_bound", b_sum, 500);
        chk("x01_frame", bits, frame_of(8'h01));
        chk("x01_parity", bits[9], 0);
        b_sum = done_cnt + err_cnt;
        start_tx(8'h00);
        dev_frame(11, 1'b1, bits);
        wait_end("x00_end_bound", b_sum, 500);
        chk("x00_frame", bits, frame_of(8'h00));
        chk("x00_parity", bits[9], 1);

        // silent device -> timeout
        b_done = done_cnt; b_err = err_cnt; b_sum = done_cnt + err_cnt;
        start_tx(PS2_CMD_ENABLE);
        wait_end("tmo_end_bound", b_sum, 14000);
        chk("tmo_err", err_cnt - b_err, 1);
        chk("tmo_latency", err_cyc - start_cyc, TO_LAT);
        chk("tmo_code", err_code, ERR_TIMEOUT);
        chk("tmo_lines_at_err", err_snap, 4'b0000);
        chk("tmo_no_done", done_cnt - b_done, 0);

        // device never ACKs
        b_done = done_cnt; b_err = err_cnt; b_sum = done_cnt + err_cnt;
        start_tx(PS2_CMD_SET_LEDS);
        dev_frame(11, 1'b0, bits);
        chk("noack_frame", bits, frame_of(8'hED));
`ifdef PS2_HOST_TX_RETRY_EN
        repeat (50) @(negedge clock);
        chk("noack_first_silent", err_cnt - b_err, 0);
        chk("noack_retry_busy", tx_busy, 1);
        dev_frame(11, 1'b0, bits);
        chk("noack_retry_frame", bits, frame_of(8'hED));
`endif
        wait_end("noack_end_bound", b_sum, 500);
        chk("noack_err", err_cnt - b_err, 1);
        chk("noack_code", err_code, ERR_NOACK);
        chk("noack_no_done", done_cnt - b_done, 0);

`ifdef PS2_HOST_TX_RETRY_EN
        // first attempt unACKed, retry ACKed
        b_done = done_cnt; b_err = err_cnt; b_sum = done_cnt + err_cnt;
        start_tx(8'h5A);
        dev_frame(11, 1'b0, bits);
        dev_frame(11, 1'b1, bits);
        wait_end("retry_end_bound", b_sum, 500);
        chk("retry_frame", bits, frame_of(8'h5A));
        chk("retry_done", done_cnt - b_done, 1);
        chk("retry_no_err", err_cnt - b_err, 0);
`endif

        // reset in the middle of a frame
        b_done = done_cnt; b_err = err_cnt;
        start_tx(PS2_CMD_SET_LEDS);
        dev_frame(5, 1'b0, bits);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("midreset_outputs", {tx_busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe, rx_inhibit}, 8'h00);
        @(posedge clock); #1 reset = 1'b1;
        repeat (100) @(negedge clock);
        chk("midreset_no_pulses", {done_cnt - b_done, err_cnt - b_err}, 64'd0);
        b_sum = done_cnt + err_cnt;
        start_tx(PS2_CMD_ENABLE);
        dev_frame(11, 1'b1, bits);
        wait_end("f4_end_bound", b_sum, 500);
        chk("f4_frame", bits, frame_of(8'hF4));
        chk("f4_parity", bits[9], 0);
        chk("f4_done", done_cnt - b_done, 1);

        // tx_start while busy is dropped
        b_inh = inh_cnt; b_done = done_cnt; b_sum = done_cnt + err_cnt;
        start_tx(PS2_CMD_SET_LEDS);
        repeat (100) @(negedge clock);
        start_tx(PS2_CMD_RESET);
        dev_frame(11, 1'b1, bits);
        wait_end("busy_end_bound", b_sum, 500);
        repeat (300) @(negedge clock);
        chk("busy_frame", bits, frame_of(8'hED));
        chk("busy_one_inhibit", inh_cnt - b_inh, INH);
        chk("busy_one_done", done_cnt - b_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
